// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue controller slice.
//   - data width, register count and register address width
//   - ALU select encodings
//   - controller state encoding
//   - instruction field bit positions
//   - offset sign-extension helper
package alu_pkg;

  localparam int DW   = 18;
  localparam int NREG = 8;
  localparam int AW   = 3;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Instruction word layout
  localparam int OP_HI   = 17;
  localparam int OP_LO   = 16;
  localparam int BEQ_BIT = 15;
  localparam int RD_HI   = 14;
  localparam int RD_LO   = 12;
  localparam int RS_HI   = 11;
  localparam int RS_LO   = 9;
  localparam int RT_HI   = 8;
  localparam int RT_LO   = 6;
  localparam int OFF_HI  = 5;
  localparam int OFF_LO  = 0;
  localparam int OFF_W   = OFF_HI - OFF_LO + 1;

  function automatic logic [DW-1:0] sext_off(input logic [OFF_W-1:0] off);
    return {{(DW-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/regfile_8x18.sv
// regfile_8x18: 8-entry x 18-bit register file, r0 hardwired to zero.
// Ports:
//   clk, rst_n          clock; asynchronous active-low clear of all entries
//   we, waddr, wdata    synchronous write port (writes to r0 are dropped)
//   ra_addr / ra_data   combinational read port A
//   rb_addr / rb_data   combinational read port B
//   dbg_addr / dbg_data combinational debug read port
module regfile_8x18
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] regs [NREG];

  // r0 has no storage; it is a constant zero.
  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      logic [DW-1:0] q_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue controller in front of an external
// combinational 18-bit ALU. Accepts one instruction per valid/ready
// handshake, reads operands from the internal register file, drives the
// ALU, captures its result/zero flag, writes back and reports beq outcome.
// Ports:
//   clk, rst_n                     clock; asynchronous active-low reset
//   instr_valid/instr_ready/instr  instruction handshake and word
//   ld_en/ld_addr/ld_data          direct register load (IDLE only)
//   dbg_addr/dbg_data              combinational register-file peek
//   alu_a/alu_b/alu_sel            registered ALU drive
//   alu_c/alu_z                    ALU result and zero flag
//   done                           one-cycle retire pulse
//   result/zero/branch_taken/branch_offset  retire outputs, held
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [DW-1:0] instr,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_sel,
  input  logic [DW-1:0] alu_c,
  input  logic          alu_z,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          branch_taken,
  output logic [DW-1:0] branch_offset
);

  state_t        state_reg;
  logic [DW-1:0] instr_reg;
  logic [DW-1:0] alu_a_reg;
  logic [DW-1:0] alu_b_reg;
  logic [1:0]    alu_sel_reg;
  logic          done_reg;
  logic [DW-1:0] result_reg;
  logic          zero_reg;
  logic          branch_taken_reg;
  logic [DW-1:0] branch_offset_reg;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;

  logic          is_beq;
  assign is_beq = instr_reg[BEQ_BIT];

  regfile_8x18 u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (instr_reg[RS_HI:RS_LO]),
    .ra_data  (rf_a),
    .rb_addr  (instr_reg[RT_HI:RT_LO]),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Single write port shared by direct loads (IDLE) and writeback (WB).
  // Writeback data comes from result_reg, which was captured from the ALU
  // at the end of EXEC. rd == 0 needs no check here: r0 has no storage.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state_reg == ST_IDLE) begin
      rf_we = ld_en;
    end else if (state_reg == ST_WB) begin
      rf_we    = ~is_beq;
      rf_waddr = instr_reg[RD_HI:RD_LO];
      rf_wdata = result_reg;
    end
  end

  // A load in IDLE blocks the handshake for that cycle.
  assign instr_ready = (state_reg == ST_IDLE) && !ld_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      instr_reg         <= '0;
      alu_a_reg         <= '0;
      alu_b_reg         <= '0;
      alu_sel_reg       <= ALU_ADD;
      done_reg          <= 1'b0;
      result_reg        <= '0;
      zero_reg          <= 1'b0;
      branch_taken_reg  <= 1'b0;
      branch_offset_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (instr_valid && !ld_en) begin
            instr_reg <= instr;
            state_reg <= ST_READ;
          end
        end
        // Operands are latched straight into the ALU drive registers so
        // they are stable for the whole EXEC cycle.
        ST_READ: begin
          alu_a_reg   <= rf_a;
          alu_b_reg   <= rf_b;
          alu_sel_reg <= is_beq ? ALU_SUB : instr_reg[OP_HI:OP_LO];
          state_reg   <= ST_EXEC;
        end
        // Capture at the end of EXEC lands directly in the retire outputs,
        // so they change in the same cycle done is high.
        ST_EXEC: begin
          result_reg        <= alu_c;
          zero_reg          <= alu_z;
          branch_taken_reg  <= is_beq & alu_z;
          branch_offset_reg <= sext_off(instr_reg[OFF_HI:OFF_LO]);
          done_reg          <= 1'b1;
          state_reg         <= ST_WB;
        end
        ST_WB: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a         = alu_a_reg;
  assign alu_b         = alu_b_reg;
  assign alu_sel       = alu_sel_reg;
  assign done          = done_reg;
  assign result        = result_reg;
  assign zero          = zero_reg;
  assign branch_taken  = branch_taken_reg;
  assign branch_offset = branch_offset_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [17:0] instr;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [17:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [17:0] dbg_data;
  logic [17:0] alu_a;
  logic [17:0] alu_b;
  logic [1:0]  alu_sel;
  logic [17:0] alu_c;
  logic        alu_z;
  logic        done;
  logic [17:0] result;
  logic        zero;
  logic        branch_taken;
  logic [17:0] branch_offset;

  typedef struct packed {
    logic [17:0] result;
    logic        zero;
    logic        taken;
    logic [17:0] off;
  } exp_t;

  exp_t        sb[$];
  logic [17:0] model_rf [8];
  int          checks;
  int          errors;

  alu_issue_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_sel       (alu_sel),
    .alu_c         (alu_c),
    .alu_z         (alu_z),
    .done          (done),
    .result        (result),
    .zero          (zero),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset)
  );

  // Behavioural stand-in for the external ALU
  always_comb begin
    alu_c = '0;
    case (alu_sel)
      2'b00: alu_c = alu_a + alu_b;
      2'b01: alu_c = alu_a - alu_b;
      2'b10: alu_c = alu_a | alu_b;
      2'b11: alu_c = alu_a & alu_b;
      default: alu_c = '0;
    endcase
  end
  assign alu_z = (alu_c == 18'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [17:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en = 1'b0;
    if (a != 3'd0) model_rf[a] = d;
  endtask

  // Drives one instruction, pushes its expected retire values, and returns
  // what the DUT produced plus timing observations.
  task automatic run_instr(input logic [1:0] op, input logic bq, input logic [2:0] rd,
                           input logic [2:0] rs, input logic [2:0] rt, input logic [5:0] off,
                           output exp_t obs, output int lat, output logic [1:0] sel_exec,
                           output logic done_after, output logic ready_after);
    exp_t        e;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] c;
    logic [1:0]  s;
    int          n;
    a = model_rf[rs];
    b = model_rf[rt];
    s = bq ? 2'b01 : op;
    case (s)
      2'b00: c = a + b;
      2'b01: c = a - b;
      2'b10: c = a | b;
      default: c = a & b;
    endcase
    e.result = c;
    e.zero   = (c == 18'd0);
    e.taken  = bq && (c == 18'd0);
    e.off    = {{12{off[5]}}, off};
    sb.push_back(e);
    if (!bq && rd != 3'd0) model_rf[rd] = c;

    instr       = {op, bq, rd, rs, rt, off};
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: instr_ready=%0b required 1", instr_ready);
    end
    step();
    instr_valid = 1'b0;
    lat      = 1;
    sel_exec = 2'b00;
    while (!done && lat < 10) begin
      if (lat == 2) sel_exec = alu_sel;
      step();
      lat++;
    end
    obs.result = result;
    obs.zero   = zero;
    obs.taken  = branch_taken;
    obs.off    = branch_offset;
    $display("instr op=%0d beq=%0b rd=%0d rs=%0d rt=%0d off=%02h -> result=%05h zero=%0b taken=%0b boff=%05h lat=%0d",
             op, bq, rd, rs, rt, off, result, zero, branch_taken, branch_offset, lat);
    step();
    done_after  = done;
    ready_after = instr_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (done !== 1'b0 || result !== 18'd0 || zero !== 1'b0 || branch_taken !== 1'b0 ||
        branch_offset !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: done=%0b result=%05h zero=%0b taken=%0b boff=%05h required all 0",
               done, result, zero, branch_taken, branch_offset);
    end
    checks++;
    if (alu_a !== 18'd0 || alu_b !== 18'd0 || alu_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_alu_drive: a=%05h b=%05h sel=%0d required 0", alu_a, alu_b, alu_sel);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: instr_ready=%0b required 1", instr_ready);
    end
    for (int i = 0; i < 8; i++) begin
      model_rf[i] = 18'd0;
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== 18'd0) begin
        errors++;
        $display("FAIL reset_rf r%0d: got %05h required 00000", i, dbg_data);
      end
    end
  endtask

  task automatic test_add();
    exp_t e, o;
    int lat;
    logic [1:0] se;
    logic da, ra;
    do_load(3'd1, 18'h00005);
    do_load(3'd2, 18'h00003);
    run_instr(2'b00, 1'b0, 3'd3, 3'd1, 3'd2, 6'd0, o, lat, se, da, ra);
    e = sb.pop_front();
    checks++;
    if (o !== e || o.result !== 18'h00008) begin
      errors++;
      $display("FAIL add_result: got res=%05h z=%0b required res=%05h z=%0b", o.result, o.zero, e.result, e.zero);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL add_latency: done after %0d cycles required 3", lat);
    end
    checks++;
    if (da !== 1'b0 || ra !== 1'b1) begin
      errors++;
      $display("FAIL add_post_retire: done=%0b ready=%0b required done=0 ready=1", da, ra);
    end
    dbg_addr = 3'd3;
    #1;
    checks++;
    if (dbg_data !== 18'h00008) begin
      errors++;
      $display("FAIL add_dbg_r3: got %05h required 00008", dbg_data);
    end
  endtask

  task automatic test_sub_and();
    exp_t e, o;
    int lat;
    logic [1:0] se;
    logic da, ra;
    do_load(3'd1, 18'h00000);
    do_load(3'd2, 18'h00001);
    run_instr(2'b01, 1'b0, 3'd4, 3'd1, 3'd2, 6'd0, o, lat, se, da, ra);
    e = sb.pop_front();
    checks++;
    if (o !== e || o.result !== 18'h3FFFF || o.zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: got res=%05h z=%0b required res=%05h z=%0b", o.result, o.zero, e.result, e.zero);
    end
    run_instr(2'b11, 1'b0, 3'd5, 3'd1, 3'd2, 6'd0, o, lat, se, da, ra);
    e = sb.pop_front();
    checks++;
    if (o !== e || o.zero !== 1'b1) begin
      errors++;
      $display("FAIL and_zero: got res=%05h z=%0b required res=%05h z=%0b", o.result, o.zero, e.result, e.zero);
    end
    dbg_addr = 3'd4;
    #1;
    checks++;
    if (dbg_data !== model_rf[4]) begin
      errors++;
      $display("FAIL sub_dbg_r4: got %05h required %05h", dbg_data, model_rf[4]);
    end
  endtask

  task automatic test_beq();
    exp_t e, o;
    int lat;
    logic [1:0] se;
    logic da, ra;
    do_load(3'd1, 18'h0000A);
    do_load(3'd2, 18'h0000A);
    // op field says OR; beq must still force subtract
    run_instr(2'b10, 1'b1, 3'd3, 3'd1, 3'd2, 6'b111110, o, lat, se, da, ra);
    e = sb.pop_front();
    checks++;
    if (se !== 2'b01) begin
      errors++;
      $display("FAIL beq_sel: alu_sel in EXEC=%0d required 1", se);
    end
    checks++;
    if (o !== e || o.taken !== 1'b1 || o.off !== 18'h3FFFE) begin
      errors++;
      $display("FAIL beq_outcome: got taken=%0b boff=%05h res=%05h required taken=%0b boff=%05h res=%05h",
               o.taken, o.off, o.result, e.taken, e.off, e.result);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== model_rf[i]) begin
        errors++;
        $display("FAIL beq_no_write r%0d: got %05h required %05h", i, dbg_data, model_rf[i]);
      end
    end
  endtask

  task automatic test_r0();
    exp_t e, o;
    int lat;
    logic [1:0] se;
    logic da, ra;
    do_load(3'd0, 18'h12345);
    do_load(3'd1, 18'h00F0F);
    do_load(3'd2, 18'h30000);
    run_instr(2'b10, 1'b0, 3'd0, 3'd1, 3'd2, 6'd5, o, lat, se, da, ra);
    e = sb.pop_front();
    checks++;
    if (o !== e || o.result === 18'd0 || lat !== 3) begin
      errors++;
      $display("FAIL or_rd0: got res=%05h lat=%0d required res=%05h lat=3", o.result, lat, e.result);
    end
    dbg_addr = 3'd0;
    #1;
    checks++;
    if (dbg_data !== 18'd0) begin
      errors++;
      $display("FAIL r0_zero: got %05h required 00000", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    int lat;
    logic [1:0] se;
    logic da, ra;
    // Load and instruction offered together: load wins this cycle
    ld_en       = 1'b1;
    ld_addr     = 3'd6;
    ld_data     = 18'h00100;
    instr_valid = 1'b1;
    instr       = {2'b00, 1'b0, 3'd7, 3'd6, 3'd1, 6'd0};
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ld_blocks_ready: instr_ready=%0b required 0", instr_ready);
    end
    step();
    ld_en = 1'b0;
    model_rf[6] = 18'h00100;
    dbg_addr = 3'd6;
    #1;
    checks++;
    if (dbg_data !== 18'h00100 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ld_priority: r6=%05h ready=%0b required r6=00100 ready=1", dbg_data, instr_ready);
    end
    run_instr(2'b00, 1'b0, 3'd7, 3'd6, 3'd1, 6'd0, o, lat, se, da, ra);
    e = sb.pop_front();
    checks++;
    if (o !== e || lat !== 3) begin
      errors++;
      $display("FAIL ld_then_add: got res=%05h lat=%0d required res=%05h lat=3", o.result, lat, e.result);
    end
    // Dependent instruction issued straight away reads r7 just written
    run_instr(2'b00, 1'b0, 3'd5, 3'd7, 3'd7, 6'd0, o, lat, se, da, ra);
    e = sb.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL dependent_add: got res=%05h required %05h", o.result, e.result);
    end
  endtask

  task automatic test_midreset();
    logic seen_done;
    instr       = {2'b00, 1'b0, 3'd4, 3'd1, 3'd2, 6'd9};
    instr_valid = 1'b1;
    step();                // accepted -> READ
    instr_valid = 1'b0;
    step();                // EXEC
    checks++;
    if (alu_a !== model_rf[1] || alu_b !== model_rf[2]) begin
      errors++;
      $display("FAIL midreset_exec_operands: a=%05h b=%05h required a=%05h b=%05h",
               alu_a, alu_b, model_rf[1], model_rf[2]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || result !== 18'd0 || zero !== 1'b0 || branch_taken !== 1'b0 ||
        branch_offset !== 18'd0 || alu_a !== 18'd0 || alu_b !== 18'd0 || alu_sel !== 2'b00) begin
      errors++;
      $display("FAIL midreset_outputs: done=%0b res=%05h z=%0b tk=%0b boff=%05h a=%05h b=%05h sel=%0d required all 0",
               done, result, zero, branch_taken, branch_offset, alu_a, alu_b, alu_sel);
    end
    for (int i = 0; i < 8; i++) begin
      model_rf[i] = 18'd0;
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== 18'd0) begin
        errors++;
        $display("FAIL midreset_rf r%0d: got %05h required 00000", i, dbg_data);
      end
    end
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: done seen=%0b required 0", seen_done);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: instr_ready=%0b required 1", instr_ready);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    dbg_addr    = '0;
    test_reset();
    test_add();
    test_sub_and();
    test_beq();
    test_r0();
    test_back_to_back();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that drives the 18-bit ALU (`sel` 00 add, 01 sub, 10 or, 11 and; combinational result `c` and zero flag `z`). It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x18 register file. It presents the operands and select to the ALU, captures `c` and `z`, writes the result back, and reports the branch-on-zero outcome. It sits between the instruction source and the ALU instance in the CPU datapath.

## Interface
- No parameters; data width fixed at 18, register count fixed at 8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  controller can accept an instruction.
- `instr`  in  18  instruction word:
  - [17:16] ALU op.
  - [15] beq.
  - [14:12] rd.
  - [11:9] rs.
  - [8:6] rt.
  - [5:0] signed offset.
- `ld_en`  in  1  direct register-file load.
- `ld_addr`  in  3  load address.
- `ld_data`  in  18  load data.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  18  combinational read of the register file.
- `alu_a`  out  18  ALU operand a.
- `alu_b`  out  18  ALU operand b.
- `alu_sel`  out  2  ALU select.
- `alu_c`  in  18  ALU result.
- `alu_z`  in  1  ALU zero flag.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `result`  out  18  captured ALU result; held until the next retire.
- `zero`  out  1  captured zero flag; held until the next retire.
- `branch_taken`  out  1  beq and zero at retire; held until the next retire.
- `branch_offset`  out  18  sign-extended [5:0] of the retired instruction.

## Operation
- States: IDLE → READ → EXEC → WB → IDLE.
- IDLE:
  - `instr_ready` = ~`ld_en`.
  - If `ld_en` is high, write `ld_data` to `ld_addr` (ignored when the address is 0). Load has priority over instruction accept.
  - On `instr_valid` && `instr_ready`, latch `instr` and go to READ.
- READ: latch reg[rs] into the a register and reg[rt] into the b register. Go to EXEC.
- EXEC:
  - Drive `alu_a` = a, `alu_b` = b.
  - Drive `alu_sel` = 01 if beq, else instr[17:16].
  - Capture `alu_c` and `alu_z` at the end of the cycle. Go to WB.
- WB:
  - Pulse `done`.
  - Update `result`, `zero`, `branch_offset`, and `branch_taken` = beq & captured z.
  - Write the result to rd unless beq or rd == 0. Go to IDLE.
- r0 always reads 0. Writes to r0 are discarded.
- `ld_en` outside IDLE is ignored. `instr_ready` is 0 outside IDLE.
- Arithmetic is modulo 2^18; sub underflow wraps (0 − 1 = 3FFFF). No carry or overflow is reported.
- `alu_a`, `alu_b`, and `alu_sel` are registered. They hold their last values outside EXEC.

## Timing
- Accept in cycle T. READ is T+1, EXEC is T+2, and `done` is high in T+3 with the updated outputs. `instr_ready` returns in T+4.
- Throughput: one instruction per 4 cycles.
- A result written in WB is visible to the READ of the next instruction.
- `dbg_data` reflects a write from the cycle after that write.
- Reset values: state IDLE; all registers 0; `alu_a` = `alu_b` = 0; `alu_sel` = 00; `result` = 0; `zero` = 0; `branch_taken` = 0; `branch_offset` = 0; `done` = 0. `instr_ready` is 1 when `ld_en` is low.
- Reset asserted mid-instruction aborts it immediately: no writeback, no `done`, and the register file is cleared.
- `instr_valid` held across WB is not accepted until IDLE.

## Structure
- Shared package `alu_pkg`:
  - Op constants `ALU_ADD` = 00, `ALU_SUB` = 01, `ALU_OR` = 10, `ALU_AND` = 11.
  - State encoding `ST_IDLE`/`ST_READ`/`ST_EXEC`/`ST_WB`.
  - Instruction field bit positions.
  - Width constant 18.
- Sub-module `regfile_8x18`:
  - Two combinational read ports plus the debug read port.
  - One synchronous write port with r0 hardwired to 0.
  - Asynchronous active-low clear.
- FSM and handshake logic stay in `alu_issue_ctrl`.

## Test plan
- Load r1 = 00005, r2 = 00003; issue add rd=3 rs=1 rt=2 → `done` at T+3, `result` = 00008, `zero` = 0; `dbg` r3 = 00008.
- r1 = 0, r2 = 1; sub rd=4 → `result` = 3FFFF, `zero` = 0. Then and rd=5 with r1=0 → `result` = 0, `zero` = 1.
- r1 = r2 = 0000A; beq with offset 6'b111110 → `alu_sel` = 01 in EXEC, `branch_taken` = 1, `branch_offset` = 3FFFE; no register changes.
- Or rd=0 with nonzero operands → `result` nonzero, `done` = 1; r0 still reads 0.
- `ld_en` and `instr_valid` both high in IDLE → load occurs, `instr_ready` = 0, instruction accepted the next cycle. Back-to-back dependent add reads the freshly written value.
- Assert `rst_n` = 0 during EXEC → all outputs 0 and the register file cleared asynchronously; no `done`. After release, `instr_ready` = 1.
